// File: rtl/csr_mach_unit.sv
// csr_mach_unit
// Machine-mode CSR file and trap sequencer for the RV32I EX stage.
// It executes CSRRW/CSRRS/CSRRC on the machine CSRs and forwards counter
// reads from the counter block. It also turns exceptions, interrupts and
// MRET into a registered, one-cycle PC redirect toward fetch.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   csr_valid/addr/op/wdata   CSR instruction in EX (op 01 RW, 10 RS, 11 RC)
//   csr_src_zero              rs1=x0 / uimm=0, which suppresses RS/RC writes
//   cnt_rdata                 counter block read data for csr_addr
//   exc_valid/cause/pc/tval   synchronous exception in EX
//   mret                      MRET in EX
//   irq_mtip, irq_meip        level-sensitive timer / external interrupt
//   int_pc, int_ok            resume PC and "interrupt may be taken now"
//   csr_rdata, csr_illegal    combinational read data / illegal access
//   redirect, redirect_pc     registered one-cycle redirect pulse and target
//
// Handshake: there is no backpressure. csr_valid, exc_valid and mret each
// qualify their payload for exactly the cycle in which they are high. The
// unit consumes that payload in the same cycle, or drops it while in REDIR.
module csr_mach_unit #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] MHARTID   = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_valid,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    input  logic        csr_src_zero,
    input  logic [31:0] cnt_rdata,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        mret,
    input  logic        irq_mtip,
    input  logic        irq_meip,
    input  logic [31:0] int_pc,
    input  logic        int_ok,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    typedef enum logic {RUN, REDIR} state_t;
    state_t state, state_nxt;

    logic        st_mie, st_mpie;
    logic        mie_mtie, mie_meie;
    logic [31:0] mtvec_q;     // bit1 is held at 0
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;      // bits [1:0] are held at 0
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;

    logic        addr_known;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        wr_req;
    logic        csr_we;
    logic [1:0]  irq_pend;    // {MEI, MTI}, already masked by mie
    logic        take_exc, take_mret, take_irq, take_trap;
    logic [3:0]  irq_cause;
    logic [3:0]  trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_target;

    // Read mux. This is the pre-write value in the same cycle.
    always_comb begin
        addr_known = 1'b1;
        old_val    = 32'h0;
        case (csr_addr)
            12'h300: old_val = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
            12'h301: old_val = 32'h4000_0100;
            12'h304: old_val = {20'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
            12'h305: old_val = mtvec_q;
            12'h340: old_val = mscratch_q;
            12'h341: old_val = mepc_q;
            12'h342: old_val = mcause_q;
            12'h343: old_val = mtval_q;
            12'h344: old_val = {20'b0, irq_meip, 3'b0, irq_mtip, 7'b0};
            12'hF14: old_val = MHARTID;
            12'hC00, 12'hC80, 12'hC02, 12'hC82: old_val = cnt_rdata;
            default: addr_known = 1'b0;
        endcase
    end

    // RS/RC with a zero source are pure reads. This matters for read-only
    // addresses (11xx), where only an actual write is illegal.
    assign wr_req      = (csr_op == 2'b01) || (csr_op[1] && !csr_src_zero);
    assign csr_illegal = csr_valid && (csr_op != 2'b00) &&
                         (!addr_known || ((csr_addr[11:10] == 2'b11) && wr_req));
    assign csr_rdata   = csr_illegal ? 32'h0 : old_val;

    always_comb begin
        new_val = old_val;
        case (csr_op)
            2'b01:   new_val = csr_wdata;
            2'b10:   new_val = old_val | csr_wdata;
            2'b11:   new_val = old_val & ~csr_wdata;
            default: new_val = old_val;
        endcase
    end

    assign csr_we = csr_valid && (csr_op != 2'b00) && wr_req && !csr_illegal &&
                    !exc_valid && (state == RUN);

    // Event selection: exception > mret > interrupt. Interrupts wait while a
    // CSR instruction is in EX, so they never race a CSR write.
    assign irq_pend  = {irq_meip & mie_meie, irq_mtip & mie_mtie};
    assign take_exc  = (state == RUN) && exc_valid;
    assign take_mret = (state == RUN) && !exc_valid && mret;
    assign take_irq  = (state == RUN) && !exc_valid && !mret && int_ok &&
                       st_mie && (irq_pend != 2'b00) && !csr_valid;
    assign take_trap = take_exc || take_irq;

    assign irq_cause  = irq_pend[1] ? 4'd11 : 4'd7;
    assign trap_cause = take_exc ? exc_cause : irq_cause;
    assign trap_pc    = take_exc ? exc_pc : int_pc;
    // Vectored mode applies only to interrupts; exceptions always use the base.
    assign trap_target = (take_irq && mtvec_q[0])
                       ? {mtvec_q[31:2], 2'b00} + {26'b0, irq_cause, 2'b00}
                       : {mtvec_q[31:2], 2'b00};

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (take_trap || take_mret) state_nxt = REDIR;
            REDIR:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_mie      <= 1'b0;
            st_mpie     <= 1'b0;
            mie_mtie    <= 1'b0;
            mie_meie    <= 1'b0;
            mtvec_q     <= {MTVEC_RST[31:2], 1'b0, MTVEC_RST[0]};
            mscratch_q  <= 32'h0;
            mepc_q      <= 32'h0;
            mcause_q    <= 32'h0;
            mtval_q     <= 32'h0;
            redirect    <= 1'b0;
            redirect_pc <= 32'h0;
        end else begin
            if (csr_we) begin
                case (csr_addr)
                    12'h300: begin
                        st_mie  <= new_val[3];
                        st_mpie <= new_val[7];
                    end
                    12'h304: begin
                        mie_mtie <= new_val[7];
                        mie_meie <= new_val[11];
                    end
                    12'h305: mtvec_q    <= {new_val[31:2], 1'b0, new_val[0]};
                    12'h340: mscratch_q <= new_val;
                    12'h341: mepc_q     <= new_val & 32'hFFFF_FFFC;
                    12'h342: mcause_q   <= new_val;
                    12'h343: mtval_q    <= new_val;
                    default: ;
                endcase
            end
            // Trap and mret updates come after the CSR write so that they win
            // if an mret shares a cycle with a CSR instruction.
            if (take_trap) begin
                mepc_q   <= trap_pc & 32'hFFFF_FFFC;
                mcause_q <= {take_irq, 27'b0, trap_cause};
                mtval_q  <= take_exc ? exc_tval : 32'h0;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end else if (take_mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end
            redirect <= take_trap || take_mret;
            if (take_trap)      redirect_pc <= trap_target;
            else if (take_mret) redirect_pc <= mepc_q;
        end
    end

endmodule

// File: doc/csr_mach_unit.md
# csr_mach_unit

Machine-mode CSR and trap unit for the 32-bit RV32I core. It sits in the EX stage beside the cycle/instret counter block. It executes CSRRW/CSRRS/CSRRC read-modify-write on the machine CSRs, forwards counter reads from the counter block, and sequences trap entry, interrupts and MRET into a one-cycle registered PC redirect to the fetch stage.

## Interface
- MTVEC_RST, 32'h0000_0000, reset value of mtvec
- MHARTID, 32'd0, value returned by mhartid

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- csr_valid  in  1  CSR instruction in EX this cycle
- csr_addr  in  12  CSR address
- csr_op  in  2  01 RW, 10 RS, 11 RC, 00 no-op
- csr_wdata  in  32  rs1 value or zero-extended uimm
- csr_src_zero  in  1  rs1=x0 / uimm=0 (suppresses RS/RC write)
- cnt_rdata  in  32  counter block read data for csr_addr
- exc_valid  in  1  synchronous exception in EX
- exc_cause  in  4  exception code
- exc_pc  in  32  PC of faulting instruction
- exc_tval  in  32  trap value
- mret  in  1  MRET in EX
- irq_mtip, irq_meip  in  1 each  level timer / external interrupt
- int_pc  in  32  PC of next instruction to execute
- int_ok  in  1  pipeline can accept an interrupt this cycle
- csr_rdata  out  32  read data (combinational)
- csr_illegal  out  1  illegal access (combinational)
- redirect  out  1  registered one-cycle redirect pulse
- redirect_pc  out  32  registered target PC

## Operation
- CSRs:
  - mstatus 0x300: MIE[3], MPIE[7], MPP[12:11] hardwired 11, others 0.
  - misa 0x301: RO 32'h4000_0100.
  - mie 0x304: MTIE[7], MEIE[11].
  - mtvec 0x305: bit0 mode, bit1 reads 0.
  - mscratch 0x340.
  - mepc 0x341: [1:0] read 0.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: RO, MTIP[7]=irq_mtip, MEIP[11]=irq_meip.
  - mhartid 0xF14.
  - 0xC00/0xC80/0xC02/0xC82 return cnt_rdata.
- Write value: RW = wdata; RS = old|wdata; RC = old&~wdata. Writes happen on RW always, and on RS/RC only if !csr_src_zero.
- csr_illegal is asserted when csr_valid and csr_op!=00, and either the address is unlisted, or csr_addr[11:10]==11 and a write would occur. csr_rdata is 0 when illegal.
- The write commits only when csr_valid && !csr_illegal && !exc_valid && state==RUN.
- FSM states RUN and REDIR; the FSM enters REDIR on any trap or mret and returns to RUN after one cycle. In REDIR, all inputs except interrupts are ignored and no interrupt is taken.
- Priority in RUN: exc_valid > mret > interrupt.
- An interrupt is taken when int_ok && MIE && (mip&mie)!=0 && !csr_valid. MEI (cause 11) beats MTI (cause 7).
- Trap entry:
  - mepc <= pc&~3, where pc is exc_pc or int_pc.
  - mcause <= {is_irq,27'b0,cause}.
  - mtval <= exc_tval, or 0 for interrupts.
  - MPIE <= MIE, MIE <= 0.
  - redirect_pc <= {mtvec[31:2],2'b00}, plus 4*cause if mode=1 and the trap is an interrupt.
- MRET: MIE <= MPIE, MPIE <= 1, redirect_pc <= mepc.

## Timing
- Reset values: all CSRs 0 except mtvec=MTVEC_RST, MPP=11. redirect=0, redirect_pc=0, state RUN.
- Reads return the pre-write value in the same cycle. Written values are visible on csr_rdata the next cycle.
- redirect rises the cycle after the triggering event and lasts exactly one cycle.
- The trap-entry CSR updates occur on the same edge that raises redirect.
- Back-to-back events: an event present during REDIR is dropped. The pipeline guarantees a flush, so no queueing is done.
- An exception in the same cycle as a CSR write cancels the write. mret with exc_valid: the exception wins.
- rst asserted mid-REDIR: outputs clear immediately (async), state RUN.

## Test plan
- Reset, read mtvec (MTVEC_RST=32'h100) -> csr_rdata=32'h100. Read mstatus -> 32'h1800. redirect=0.
- CSRRW mscratch 0xDEADBEEF, then CSRRS mscratch with wdata 0x0F -> first read returns 0, second returns 0xDEADBEEF, final value 0xDEADBEEF.
- CSRRW to 0xC00 -> csr_illegal=1, no state change. CSRRS 0xC00 with csr_src_zero=1 -> legal, csr_rdata=cnt_rdata.
- exc_valid cause 11, exc_pc 0x204, mtvec 0x100, MIE=1 -> next cycle redirect=1, redirect_pc=0x100, mepc=0x204, mcause=11, mstatus MIE=0/MPIE=1. Following cycle redirect=0.
- mtvec=0x101, mie=0x800, MIE=1, irq_meip=1, int_ok=1 -> redirect_pc=0x12C, mcause=0x8000_000B. Then mret -> redirect_pc=int_pc, MIE=1.
- irq_mtip and irq_meip both high, both enabled -> cause 11 taken. Same-cycle exc_valid -> exception taken instead, mcause[31]=0.
